// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared types and helpers for the sequential binary-to-BCD converter.
//   state_t        - converter FSM states (IDLE, SHIFT, DONE)
//   MAX_DIGITS     - widest supported BCD result, in digits
//   bcd_all_nines  - saturation pattern: the low `digits` nibbles set to 9
//   cnt_width      - bit-counter width, $clog2(bin_w) but never below 1
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int MAX_DIGITS = 10;

    // Returns a full-width pattern; callers keep only the low 4*digits bits.
    function automatic logic [4*MAX_DIGITS-1:0] bcd_all_nines(input int digits);
        logic [4*MAX_DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    function automatic int cnt_width(input int bin_w);
        return (bin_w <= 1) ? 1 : $clog2(bin_w);
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: one double-dabble correction cell.
//   digit    in  4  BCD digit before the shift
//   adjusted out 4  digit + 3 when digit >= 5, otherwise unchanged
// The +3 wraps within 4 bits; the carry into the next digit is produced by
// the following left shift, not by this cell.
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: multi-cycle binary-to-BCD converter, one input bit per clock.
//   Clk       in  1       system clock, rising edge
//   Reset_n   in  1       asynchronous active-low reset
//   in_valid  in  1       bin is valid this cycle
//   in_ready  out 1       converter can accept a value (IDLE only)
//   bin       in  BIN_W   unsigned binary value
//   out_valid out 1       bcd/blank/overflow valid, held until out_ready
//   out_ready in  1       consumer accepts the result
//   bcd       out BCD_W   packed BCD, digit 0 in bits [3:0]
//   blank     out DIGITS  1 = leading-zero digit (digit 0 never blanked)
//   overflow  out 1       bin > 10^DIGITS-1, bcd saturated to all nines
// Result appears BIN_W clocks after the accept edge; a new value can be
// accepted every BIN_W+2 clocks when out_ready is held high.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIN_W-1:0]    bin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] bcd,
    output logic [DIGITS-1:0]   blank,
    output logic                overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = cnt_width(BIN_W);
    localparam int CAT_W = BCD_W + BIN_W + 1;

    localparam logic [4*MAX_DIGITS-1:0] NINES_ALL = bcd_all_nines(DIGITS);
    localparam logic [BCD_W-1:0]        NINES     = NINES_ALL[BCD_W-1:0];

    state_t             state_reg;
    logic [BIN_W-1:0]   sreg_reg;
    logic [BCD_W-1:0]   acc_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               ovf_reg;

    logic [BCD_W-1:0]   adj;
    logic [CAT_W-1:0]   cat;
    logic [BCD_W-1:0]   acc_next;
    logic [BIN_W-1:0]   sreg_next;
    logic               ovf_next;
    logic [BCD_W-1:0]   result_next;
    logic [DIGITS-1:0]  blank_next;

    // Per-digit "+3 if >= 5" correction ahead of the shift.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
        bcd_add3 u_add3 (
            .digit    (acc_reg[4*gi +: 4]),
            .adjusted (adj[4*gi +: 4])
        );
    end

    // {adj, sreg} shifted left by one. The extra LSB lets the top bit of the
    // corrected accumulator fall out at cat[CAT_W-1] for overflow detection,
    // and keeps the slicing valid for BIN_W == 1.
    assign cat       = {adj, sreg_reg, 1'b0};
    assign acc_next  = cat[CAT_W-2 -: BCD_W];
    assign sreg_next = cat[BIN_W-1:0];

    // A 1 leaving the top digit means the partial value already reached
    // 10^DIGITS; once set it stays set for the rest of the conversion.
    assign ovf_next    = ovf_reg | cat[CAT_W-1];
    assign result_next = ovf_next ? NINES : acc_next;

    // Leading-zero mask: digit i is blank when it and every digit above it
    // are zero. Digit 0 always shows so a zero value displays "0".
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
        if (gi == 0) begin : g_lsd
            assign blank_next[gi] = 1'b0;
        end else begin : g_upper
            assign blank_next[gi] = ~|result_next[BCD_W-1:4*gi];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
            sreg_reg  <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            bcd       <= '0;
            blank     <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sreg_reg  <= bin;
                        acc_reg   <= '0;
                        ovf_reg   <= 1'b0;
                        cnt_reg   <= CNT_W'(BIN_W - 1);
                        in_ready  <= 1'b0;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_reg  <= acc_next;
                    sreg_reg <= sreg_next;
                    ovf_reg  <= ovf_next;
                    if (cnt_reg == '0) begin
                        bcd       <= result_next;
                        blank     <= blank_next;
                        overflow  <= ovf_next;
                        out_valid <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                DONE: begin
                    // Outputs hold until the consumer takes them.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed-vector bench for bin2bcd_seq.
// Instance a uses the default 14-bit / 4-digit configuration, instance b a
// 20-bit / 6-digit configuration. Expected values are hand-computed constants.
module tb_bin2bcd_seq;

    logic clk;
    logic rst_n;

    logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, overflow_a;
    logic [13:0] bin_a;
    logic [15:0] bcd_a;
    logic [3:0]  blank_a;

    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, overflow_b;
    logic [19:0] bin_b;
    logic [23:0] bcd_b;
    logic [5:0]  blank_b;

    int n_vec = 0;
    int n_err = 0;

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) u_dut_a (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .bin       (bin_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
        .bcd       (bcd_a),
        .blank     (blank_a),
        .overflow  (overflow_a)
    );

    bin2bcd_seq #(.BIN_W(20), .DIGITS(6)) u_dut_b (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .bin       (bin_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .bcd       (bcd_b),
        .blank     (blank_b),
        .overflow  (overflow_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full transaction on instance a (sel=0) or b (sel=1), out_ready high.
    task automatic run_vec(input bit sel, input logic [31:0] value,
                           input logic [39:0] exp_bcd, input logic [9:0] exp_blank,
                           input logic exp_ovf);
        int lat;
        int exp_lat;
        exp_lat = sel ? 20 : 14;
        @(negedge clk);
        check("ready_idle", sel ? in_ready_b : in_ready_a, 1);
        if (sel) begin
            in_valid_b = 1'b1;
            bin_b      = value[19:0];
        end else begin
            in_valid_a = 1'b1;
            bin_a      = value[13:0];
        end
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        check("ready_busy", sel ? in_ready_b : in_ready_a, 0);
        lat = 0;
        while (lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
            if (sel ? out_valid_b : out_valid_a) break;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("bcd", sel ? 64'(bcd_b) : 64'(bcd_a), 64'(exp_bcd));
        check("blank", sel ? 64'(blank_b) : 64'(blank_a), 64'(exp_blank));
        check("overflow", sel ? overflow_b : overflow_a, 64'(exp_ovf));
        $display("xfer dut=%s bin=%0d bcd=%h blank=%b ovf=%b lat=%0d",
                 sel ? "b" : "a", value, sel ? 40'(bcd_b) : 40'(bcd_a),
                 sel ? 10'(blank_b) : 10'(blank_a), sel ? overflow_b : overflow_a, lat);
        @(posedge clk);
        #1;
        check("valid_drop", sel ? out_valid_b : out_valid_a, 0);
        check("ready_back", sel ? in_ready_b : in_ready_a, 1);
    endtask

    initial begin
        int lat;
        rst_n       = 1'b1;
        in_valid_a  = 1'b0;
        in_valid_b  = 1'b0;
        out_ready_a = 1'b1;
        out_ready_b = 1'b1;
        bin_a       = '0;
        bin_b       = '0;
        #3 rst_n = 1'b0;
        #1;
        check("rst_ready", in_ready_a, 1);
        check("rst_valid", out_valid_a, 0);
        check("rst_bcd", bcd_a, 0);
        check("rst_blank", blank_a, 0);
        check("rst_ovf", overflow_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Default configuration, directed values.
        run_vec(0, 1234,  40'h1234, 10'b0000, 1'b0);
        run_vec(0, 0,     40'h0000, 10'b1110, 1'b0);
        run_vec(0, 7,     40'h0007, 10'b1110, 1'b0);
        run_vec(0, 40,    40'h0040, 10'b1100, 1'b0);
        run_vec(0, 9999,  40'h9999, 10'b0000, 1'b0);
        run_vec(0, 10000, 40'h9999, 10'b0000, 1'b1);
        run_vec(0, 16383, 40'h9999, 10'b0000, 1'b1);

        // Backpressure: result held, extra in_valid pulses ignored.
        out_ready_a = 1'b0;
        @(negedge clk);
        in_valid_a = 1'b1;
        bin_a      = 14'd305;
        @(posedge clk);
        #1 in_valid_a = 1'b0;
        lat = 0;
        while (lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid_a) break;
        end
        check("bp_latency", 64'(lat), 14);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid_a = 1'b1;
            bin_a      = 14'd999;
            @(posedge clk);
            #1;
            check("bp_valid", out_valid_a, 1);
            check("bp_bcd", bcd_a, 16'h0305);
            check("bp_blank", blank_a, 4'b1000);
            check("bp_ready", in_ready_a, 0);
        end
        @(negedge clk);
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        @(posedge clk);
        #1;
        $display("xfer dut=a bin=305 bcd=%h blank=%b ovf=%b held=5", bcd_a, blank_a, overflow_a);
        check("bp_release", out_valid_a, 0);
        check("bp_hold_bcd", bcd_a, 16'h0305);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_queue", out_valid_a, 0);
        check("bp_ready_idle", in_ready_a, 1);

        // Reset in the middle of a conversion.
        @(negedge clk);
        in_valid_a = 1'b1;
        bin_a      = 14'd4321;
        @(posedge clk);
        #1 in_valid_a = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("mid_busy", in_ready_a, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid_a, 0);
        check("mid_rst_ready", in_ready_a, 1);
        check("mid_rst_bcd", bcd_a, 0);
        check("mid_rst_blank", blank_a, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("xfer dut=a bin=4321 aborted by reset");
        run_vec(0, 58, 40'h0058, 10'b1100, 1'b0);

        // Wider configuration.
        run_vec(1, 0,       40'h000000, 10'b111110, 1'b0);
        run_vec(1, 1,       40'h000001, 10'b111110, 1'b0);
        run_vec(1, 4321,    40'h004321, 10'b110000, 1'b0);
        run_vec(1, 123456,  40'h123456, 10'b000000, 1'b0);
        run_vec(1, 999999,  40'h999999, 10'b000000, 1'b0);
        run_vec(1, 1000000, 40'h999999, 10'b000000, 1'b1);
        run_vec(1, 1048575, 40'h999999, 10'b000000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Multi-cycle, parametrised binary-to-BCD converter (shift-and-add-3, one input bit per clock) with valid/ready handshakes on input and output.
- Adds saturation/overflow detection and a leading-zero blanking mask for the score and height hex-digit display path.
- Sits between game score/height counters and the 7-segment/sprite digit renderer.
- Trades latency for area against a fully unrolled combinational converter.

Parameters:
- BIN_W, 14, width of binary input (legal range 1..32).
- DIGITS, 4, number of BCD output digits (legal range 1..10). BCD_W = 4*DIGITS.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  bin is valid this cycle.
- in_ready  out  1  converter can accept a value.
- bin  in  BIN_W  unsigned binary value.
- out_valid  out  1  bcd/blank/overflow are valid.
- out_ready  in  1  consumer accepts the result.
- bcd  out  BCD_W  packed BCD; digit i is bits [4i+3:4i], digit 0 is least significant.
- blank  out  DIGITS  1 = digit is a leading zero and should be blanked.
- overflow  out  1  bin exceeded 10^DIGITS-1; bcd is saturated.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; in_ready=1; out_valid=0; bcd=0; blank=0; overflow=0.
  - Internal shift register, BCD accumulator and counter are cleared.
- FSM states IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch bin into the shift register, clear the accumulator and sticky ovf, set cnt=BIN_W-1, and go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each clock, every digit of the accumulator that is >=5 gets +3 (4-bit, no carry between digits).
  - Then shift {acc, sreg} left by 1, so the MSB of bin enters acc[0].
  - The bit shifted out of acc[BCD_W-1] ORs into the sticky ovf.
  - When cnt==0, the last shift completes, outputs are registered and the state goes to DONE. Otherwise cnt decrements.
- Output register load (on the SHIFT→DONE edge):
  - If ovf=1: bcd = all digits 9, overflow=1, blank=0.
  - Else: bcd = final acc, overflow=0.
  - blank[i]=1 iff digits DIGITS-1..i are all zero, for i>=1. blank[0] is always 0, so a value of 0 displays "0".
- DONE:
  - out_valid=1, in_ready=0.
  - bcd/blank/overflow are held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE and drop out_valid on the next edge.
  - Output registers keep their last value after leaving DONE.
- Latency and throughput:
  - out_valid rises exactly BIN_W clocks after the accept edge.
  - Minimum spacing between accepts is BIN_W+2 clocks with out_ready held high.
- in_valid while busy is ignored; the value is not queued.
- Reset asserted mid-SHIFT or mid-DONE aborts the conversion; all outputs return to reset values immediately. No partial result is ever presented.
- BIN_W=1 is legal: a single SHIFT cycle.
- If 2^BIN_W-1 <= 10^DIGITS-1, overflow can never assert. Overflow logic may be tied off under generate.

Decomposition:
- bin2bcd_pkg:
  - state enum (IDLE, SHIFT, DONE).
  - function bcd_all_nines(DIGITS).
  - function counter width, $clog2(BIN_W) with minimum 1.
- Sub-module bcd_add3: 4-bit combinational "if >=5 add 3" cell, instantiated DIGITS times via generate.
- Blank mask: a generate loop in the top module.

Test Plan:
- Defaults, bin=1234 with out_ready=1 -> out_valid exactly 14 clocks after accept; bcd=16'h1234, blank=4'b0000, overflow=0; out_valid high for 1 cycle.
- bin=0 -> bcd=16'h0000, blank=4'b1110; bin=7 -> bcd=16'h0007, blank=4'b1110; bin=40 -> bcd=16'h0040, blank=4'b1100.
- bin=9999 -> bcd=16'h9999, overflow=0; bin=10000 and bin=16383 -> bcd=16'h9999, overflow=1, blank=0.
- Backpressure: bin=305, hold out_ready=0 for 5 cycles -> out_valid, bcd=16'h0305 and blank=4'b1000 stable; in_ready=0 throughout; in_valid pulses are ignored; release gives one transfer.
- Reset_n pulsed low at SHIFT cycle 6 of bin=4321 -> outputs zero asynchronously, in_ready=1 after release; a new bin=58 yields 16'h0058 with no trace of 4321.
- Sweep with BIN_W=20, DIGITS=6, random and exhaustive edge values (0, 999999, 1048575) against a reference model -> 20-cycle latency, correct bcd, overflow only when bin >= 1000000.
